unified_mem_arbiter: RTL

Arbitrates a single multi-cycle memory port between the instruction-fetch stage and the data-memory stage of the five-stage LEGv8 pipeline. It issues one request at a time, holds it until the memory acknowledges, and returns the read data with a one-cycle ready pulse. It also drives the stall signals that freeze the pipeline registers while a requester waits. It sits between the IF/MEM stage logic and the external memory model, below the top-level `cpu`.

---
 rtl/unified_mem_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Purpose : shares one multi-cycle memory port between instruction fetch and data access.
// Latency : request sampled at edge N -> mem_req in cycle N+1; mem_ack at edge K -> ready in cycle K+1.
// Backpressure: one access in flight; requesters hold their request and are stalled until ready.
//
// Ports
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_if_req/i_if_addr      : fetch request and byte address (bit 2 picks the 32-bit half)
//   o_if_rdata/o_if_ready   : fetched instruction and its one-cycle completion pulse
//   i_d_rd/i_d_wr/i_d_addr/i_d_wdata : data request (write wins over read)
//   o_d_rdata/o_d_ready     : data read result and its one-cycle completion pulse
//   o_mem_*/i_mem_rdata/i_mem_ack    : external memory handshake
//   o_err                   : abort flag, pulses with a ready pulse
//   o_stall_if/o_stall_mem  : combinational pipeline freeze signals
//
// Optional feature macro: MEM_TIMEOUT_EN (watchdog that aborts a request after
// TIMEOUT_CYCLES wait cycles). Without it the block waits forever and o_err is 0.
module unified_mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [63:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_ready,
  input  logic        i_d_rd,
  input  logic        i_d_wr,
  input  logic [63:0] i_d_addr,
  input  logic [63:0] i_d_wdata,
  output logic [63:0] o_d_rdata,
  output logic        o_d_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_wdata,
  input  logic [63:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_err,
  output logic        o_stall_if,
  output logic        o_stall_mem
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_IF_WAIT, S_D_WAIT, S_DONE} state_t;

  state_t        r_state;
  logic [SW-1:0] r_starve_cnt;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [63:0]   r_mem_addr;
  logic [63:0]   r_mem_wdata;
  logic [31:0]   r_if_rdata;
  logic          r_if_ready;
  logic [63:0]   r_d_rdata;
  logic          r_d_ready;
  logic          r_hi_half;   // if_addr[2] captured at grant; inputs are not watched after IDLE
  logic          r_d_is_rd;   // granted data access was a read (writes leave d_rdata alone)

  logic w_d_req;
  logic w_grant_if;
  logic w_grant_d;

  assign w_d_req    = i_d_rd | i_d_wr;
  // Fetch wins when no data request is pending, or when it has waited out STARVE_LIMIT data grants.
  assign w_grant_if = i_if_req & (~w_d_req | (r_starve_cnt == STARVE_MAX));
  assign w_grant_d  = w_d_req & ~w_grant_if;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wdog;
  logic          r_err;
  logic          w_wdog_exp;
  // Expires on the last allowed wait cycle, so mem_req is high for exactly TIMEOUT_CYCLES cycles.
  assign w_wdog_exp = (r_wdog == TW'(TIMEOUT_CYCLES - 1));
  assign o_err      = r_err;
`else
  logic w_unused_param;
  assign w_unused_param = TIMEOUT_CYCLES[0];
  assign o_err          = 1'b0;
`endif

  logic w_unused_addr;
  assign w_unused_addr = ^i_if_addr[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_if_ready   <= 1'b0;
      r_d_rdata    <= '0;
      r_d_ready    <= 1'b0;
      r_hi_half    <= 1'b0;
      r_d_is_rd    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_wdog       <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      // Ready and err are pulses: only the transition into DONE raises them.
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_grant_if) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {i_if_addr[63:3], 3'b000};
            r_hi_half    <= i_if_addr[2];
            r_starve_cnt <= '0;
            r_state      <= S_IF_WAIT;
`ifdef MEM_TIMEOUT_EN
            r_wdog       <= '0;
`endif
          end else if (w_grant_d) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= i_d_wr;
            r_mem_addr <= i_d_addr;
            r_d_is_rd  <= ~i_d_wr;
            if (i_d_wr) begin
              r_mem_wdata <= i_d_wdata;
            end
            if (i_if_req && (r_starve_cnt != STARVE_MAX)) begin
              r_starve_cnt <= r_starve_cnt + SW'(1);
            end
            r_state <= S_D_WAIT;
`ifdef MEM_TIMEOUT_EN
            r_wdog  <= '0;
`endif
          end
        end
        S_IF_WAIT, S_D_WAIT: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            if (r_state == S_IF_WAIT) begin
              r_if_rdata <= r_hi_half ? i_mem_rdata[63:32] : i_mem_rdata[31:0];
              r_if_ready <= 1'b1;
            end else begin
              if (r_d_is_rd) begin
                r_d_rdata <= i_mem_rdata;
              end
              r_d_ready <= 1'b1;
            end
            r_state <= S_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (w_wdog_exp) begin
            // Abort: complete the access with zero read data and flag it.
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            if (r_state == S_IF_WAIT) begin
              r_if_rdata <= '0;
              r_if_ready <= 1'b1;
            end else begin
              if (r_d_is_rd) begin
                r_d_rdata <= '0;
              end
              r_d_ready <= 1'b1;
            end
            r_state <= S_DONE;
          end else begin
            r_wdog <= r_wdog + TW'(1);
          end
`endif
        end
        // No grant here: the requester still holds the request it just got served.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_if_ready  = r_if_ready;
  assign o_d_rdata   = r_d_rdata;
  assign o_d_ready   = r_d_ready;
  assign o_stall_if  = i_if_req & ~r_if_ready;
  assign o_stall_mem = w_d_req & ~r_d_ready;

endmodule
